// File: rtl/score_counter.sv
`default_nettype none
// ============================================================================
// Module      : score_counter
// Description : Three debounced buttons (inc/dec/clr) driving a saturating
//               0..15 score with limit flags. Define SCORE_BLINK_EN to make
//               the display blink while the score sits at 15.
// Revision    : 1.0 - initial release
// ============================================================================
module score_counter #(
  parameter int DB_CYCLES    = 50000,
  parameter int BLINK_CYCLES = 25000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_inc,
  input  logic       btn_dec,
  input  logic       btn_clr,
  output logic [4:0] data,
  output logic       at_max,
  output logic       at_min
);

  typedef enum logic [1:0] {
    RELEASED   = 2'd0,
    DB_PRESS   = 2'd1,
    HELD       = 2'd2,
    DB_RELEASE = 2'd3
  } db_state_t;

  localparam int          c_num_btn = 3;
  localparam logic [15:0] c_db_last = 16'(DB_CYCLES - 2);
  localparam logic [3:0]  c_max     = 4'd15;

  if (DB_CYCLES < 2 || DB_CYCLES > 65535 ||
      BLINK_CYCLES < 2 || BLINK_CYCLES > 33554431) begin : g_cfg_check
    $error("score_counter: parameter out of supported range");
  end

  logic [c_num_btn-1:0] w_btn_raw;
  logic [c_num_btn-1:0] r_sync1;
  logic [c_num_btn-1:0] r_sync2;
  logic [c_num_btn-1:0] w_pulse;

  assign w_btn_raw = {btn_clr, btn_dec, btn_inc};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= w_btn_raw;
      r_sync2 <= r_sync1;
    end
  end

  for (genvar g = 0; g < c_num_btn; g++) begin : g_debounce
    db_state_t   r_state;
    db_state_t   w_state_nxt;
    logic [15:0] r_cnt;
    logic [15:0] w_cnt_nxt;
    logic        r_pulse;
    logic        w_pulse_nxt;
    logic        w_in;

    assign w_in = r_sync2[g];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_state <= RELEASED;
        r_cnt   <= '0;
        r_pulse <= 1'b0;
      end else begin
        r_state <= w_state_nxt;
        r_cnt   <= w_cnt_nxt;
        r_pulse <= w_pulse_nxt;
      end
    end

    // The entry edge itself counts as the first stable cycle, so the final
    // transition fires when the counter reaches DB_CYCLES-2.
    always_comb begin
      w_state_nxt = r_state;
      w_pulse_nxt = 1'b0;
      case (r_state)
        RELEASED: begin
          if (w_in) w_state_nxt = DB_PRESS;
        end
        DB_PRESS: begin
          if (!w_in) begin
            w_state_nxt = RELEASED;
          end else if (r_cnt == c_db_last) begin
            w_state_nxt = HELD;
            w_pulse_nxt = 1'b1;
          end
        end
        HELD: begin
          if (!w_in) w_state_nxt = DB_RELEASE;
        end
        DB_RELEASE: begin
          if (w_in) begin
            w_state_nxt = HELD;
          end else if (r_cnt == c_db_last) begin
            w_state_nxt = RELEASED;
          end
        end
        default: w_state_nxt = RELEASED;
      endcase

      w_cnt_nxt = '0;
      if (w_state_nxt == r_state &&
          (r_state == DB_PRESS || r_state == DB_RELEASE)) begin
        w_cnt_nxt = r_cnt + 16'd1;
      end
    end

    assign w_pulse[g] = r_pulse;
  end

  logic       w_inc;
  logic       w_dec;
  logic       w_clr;
  logic [3:0] r_count;
  logic [3:0] w_count_nxt;

  assign w_inc = w_pulse[0];
  assign w_dec = w_pulse[1];
  assign w_clr = w_pulse[2];

  always_comb begin
    w_count_nxt = r_count;
    if (w_clr) begin
      w_count_nxt = 4'd0;
    end else if (w_inc && !w_dec) begin
      if (r_count != c_max) w_count_nxt = r_count + 4'd1;
    end else if (w_dec && !w_inc) begin
      if (r_count != 4'd0) w_count_nxt = r_count - 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_count <= 4'd0;
    else     r_count <= w_count_nxt;
  end

  assign at_max = (r_count == c_max);
  assign at_min = (r_count == 4'd0);

`ifdef SCORE_BLINK_EN
  localparam logic [24:0] c_blink_last = 25'(BLINK_CYCLES - 1);

  logic [24:0] r_blink_cnt;
  logic        r_blank;

  // Clearing on the edge that leaves 15 keeps blank from lingering a cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_blink_cnt <= '0;
      r_blank     <= 1'b0;
    end else if (w_count_nxt != c_max || r_count != c_max) begin
      r_blink_cnt <= '0;
      r_blank     <= 1'b0;
    end else if (r_blink_cnt == c_blink_last) begin
      r_blink_cnt <= '0;
      r_blank     <= ~r_blank;
    end else begin
      r_blink_cnt <= r_blink_cnt + 25'd1;
    end
  end

  assign data = (at_max && r_blank) ? 5'b11111 : {1'b0, r_count};
`else
  assign data = {1'b0, r_count};
`endif

endmodule
`default_nettype wire

// File: tb/tb_score_counter.sv
`default_nettype none
// Directed self-checking bench for score_counter with DB_CYCLES=4, BLINK_CYCLES=8.
module tb_score_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_inc = 1'b0;
  logic       btn_dec = 1'b0;
  logic       btn_clr = 1'b0;
  logic [4:0] data;
  logic       at_max;
  logic       at_min;

  int n_vec = 0;
  int n_err = 0;

  score_counter #(.DB_CYCLES(4), .BLINK_CYCLES(8)) dut (
    .clk(clk), .rst(rst), .btn_inc(btn_inc), .btn_dec(btn_dec),
    .btn_clr(btn_clr), .data(data), .at_max(at_max), .at_min(at_min)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive the selected buttons together long enough to qualify, then release.
  task automatic press(input logic i, input logic d, input logic c);
    btn_inc = i; btn_dec = d; btn_clr = c;
    step(8);
    btn_inc = 1'b0; btn_dec = 1'b0; btn_clr = 1'b0;
    step(10);
  endtask

  task automatic do_reset;
    btn_inc = 1'b0; btn_dec = 1'b0; btn_clr = 1'b0;
    rst = 1'b1;
    step(3);
    rst = 1'b0;
    step(1);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    step(2);
    n_vec++; if (data !== 5'b00000) begin n_err++; $display("FAIL reset_data got=%b exp=%b", data, 5'b00000); end
    n_vec++; if (at_max !== 1'b0) begin n_err++; $display("FAIL reset_at_max got=%b exp=0", at_max); end
    n_vec++; if (at_min !== 1'b1) begin n_err++; $display("FAIL reset_at_min got=%b exp=1", at_min); end
    rst = 1'b0;
    step(1);
  endtask

  task automatic test_latency;
    do_reset();
    btn_inc = 1'b1;
    step(6);
    n_vec++; if (data !== 5'd0) begin n_err++; $display("FAIL latency_early got=%0d exp=0", data); end
    step(1);
    n_vec++; if (data !== 5'd1) begin n_err++; $display("FAIL latency_edge got=%0d exp=1", data); end
    step(13);
    n_vec++; if (data !== 5'd1) begin n_err++; $display("FAIL latency_held got=%0d exp=1", data); end
    btn_inc = 1'b0;
    step(10);
    n_vec++; if (data !== 5'd1) begin n_err++; $display("FAIL latency_release got=%0d exp=1", data); end
  endtask

  task automatic test_glitch;
    do_reset();
    btn_inc = 1'b1;
    step(3);
    btn_inc = 1'b0;
    step(15);
    n_vec++; if (data !== 5'd0) begin n_err++; $display("FAIL glitch_data got=%0d exp=0", data); end
    n_vec++; if (at_min !== 1'b1) begin n_err++; $display("FAIL glitch_at_min got=%b exp=1", at_min); end
  endtask

  task automatic test_saturate;
    logic data_ok;
    do_reset();
    for (int k = 0; k < 16; k++) press(1'b1, 1'b0, 1'b0);
`ifdef SCORE_BLINK_EN
    data_ok = (data === 5'b01111) || (data === 5'b11111);
`else
    data_ok = (data === 5'b01111);
`endif
    n_vec++; if (!data_ok) begin n_err++; $display("FAIL sat_max_data got=%b exp=01111", data); end
    n_vec++; if (at_max !== 1'b1) begin n_err++; $display("FAIL sat_at_max got=%b exp=1", at_max); end
    n_vec++; if (at_min !== 1'b0) begin n_err++; $display("FAIL sat_at_min got=%b exp=0", at_min); end
    press(1'b1, 1'b0, 1'b0);
    n_vec++; if (at_max !== 1'b1) begin n_err++; $display("FAIL sat_17th at_max got=%b exp=1", at_max); end
    press(1'b0, 1'b0, 1'b1);
    n_vec++; if (data !== 5'd0) begin n_err++; $display("FAIL sat_clear got=%0d exp=0", data); end
    press(1'b0, 1'b1, 1'b0);
    n_vec++; if (data !== 5'd0) begin n_err++; $display("FAIL sat_dec_min got=%0d exp=0", data); end
    n_vec++; if (at_min !== 1'b1) begin n_err++; $display("FAIL sat_dec_at_min got=%b exp=1", at_min); end
  endtask

  task automatic test_simultaneous;
    do_reset();
    for (int k = 0; k < 5; k++) press(1'b1, 1'b0, 1'b0);
    n_vec++; if (data !== 5'd5) begin n_err++; $display("FAIL sim_setup got=%0d exp=5", data); end
    press(1'b1, 1'b1, 1'b0);
    n_vec++; if (data !== 5'd5) begin n_err++; $display("FAIL sim_inc_dec got=%0d exp=5", data); end
    press(1'b0, 1'b1, 1'b0);
    n_vec++; if (data !== 5'd4) begin n_err++; $display("FAIL sim_dec got=%0d exp=4", data); end
    press(1'b1, 1'b0, 1'b1);
    n_vec++; if (data !== 5'd0) begin n_err++; $display("FAIL sim_inc_clr got=%0d exp=0", data); end
    n_vec++; if (at_min !== 1'b1) begin n_err++; $display("FAIL sim_inc_clr_at_min got=%b exp=1", at_min); end
  endtask

`ifdef SCORE_BLINK_EN
  task automatic test_blink;
    logic saw_blank;
    do_reset();
    for (int k = 0; k < 14; k++) press(1'b1, 1'b0, 1'b0);
    btn_inc = 1'b1;
    step(7);
    n_vec++; if (data !== 5'b01111) begin n_err++; $display("FAIL blink_enter got=%b exp=01111", data); end
    step(7);
    n_vec++; if (data !== 5'b01111) begin n_err++; $display("FAIL blink_show_end got=%b exp=01111", data); end
    step(1);
    n_vec++; if (data !== 5'b11111) begin n_err++; $display("FAIL blink_blank_start got=%b exp=11111", data); end
    step(7);
    n_vec++; if (data !== 5'b11111) begin n_err++; $display("FAIL blink_blank_end got=%b exp=11111", data); end
    step(1);
    n_vec++; if (data !== 5'b01111) begin n_err++; $display("FAIL blink_show_again got=%b exp=01111", data); end
    btn_inc = 1'b0;
    step(10);
    btn_dec = 1'b1;
    saw_blank = 1'b0;
    for (int k = 0; k < 7; k++) step(1);
    btn_dec = 1'b0;
    n_vec++; if (data !== 5'd14) begin n_err++; $display("FAIL blink_dec got=%b exp=01110", data); end
    for (int k = 0; k < 30; k++) begin
      step(1);
      if (data === 5'b11111 || data !== 5'd14) saw_blank = 1'b1;
    end
    n_vec++; if (saw_blank !== 1'b0) begin n_err++; $display("FAIL blink_after_dec unsteady got=%b exp=01110", data); end
  endtask
`endif

  task automatic test_reset_mid;
    do_reset();
    for (int k = 0; k < 9; k++) press(1'b1, 1'b0, 1'b0);
    n_vec++; if (data !== 5'd9) begin n_err++; $display("FAIL rstmid_setup got=%0d exp=9", data); end
    btn_inc = 1'b1;
    step(4);
    rst = 1'b1;
    #1;
    n_vec++; if (data !== 5'd0) begin n_err++; $display("FAIL rstmid_async_data got=%0d exp=0", data); end
    n_vec++; if (at_min !== 1'b1) begin n_err++; $display("FAIL rstmid_async_at_min got=%b exp=1", at_min); end
    step(2);
    rst = 1'b0;
    step(3);
    btn_inc = 1'b0;
    step(12);
    n_vec++; if (data !== 5'd0) begin n_err++; $display("FAIL rstmid_no_inc got=%0d exp=0", data); end
    press(1'b1, 1'b0, 1'b0);
    n_vec++; if (data !== 5'd1) begin n_err++; $display("FAIL rstmid_recover got=%0d exp=1", data); end
  endtask

  initial begin
    step(1);
    test_reset();
    test_latency();
    test_glitch();
    test_saturate();
    test_simultaneous();
`ifdef SCORE_BLINK_EN
    test_blink();
`endif
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
